// File: rtl/fir_tdm_pkg.sv
// Shared types and width helpers for the time-multiplexed FIR filter family.
package fir_tdm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      OUT  = 2'd2
   } fir_state_e;

   // Channel index width; a single channel still needs one bit.
   function automatic int unsigned fir_ch_w(input int unsigned num_ch);
      return (num_ch > 1) ? 32'($clog2(num_ch)) : 32'd1;
   endfunction

   function automatic int unsigned fir_tap_w(input int unsigned num_taps);
      return (num_taps > 1) ? 32'($clog2(num_taps)) : 32'd1;
   endfunction

   // Accumulator wide enough that summing num_taps full-scale products never overflows.
   function automatic int unsigned fir_acc_w(input int unsigned data_w,
                                             input int unsigned coef_w,
                                             input int unsigned num_taps);
      return data_w + coef_w + 32'($clog2(num_taps));
   endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Combinational round-half-up and saturate from an accumulator to the output width.
module fir_round_sat #(
   parameter int unsigned ACC_W     = 19,
   parameter int unsigned OUT_W     = 9,
   parameter int unsigned FRAC_BITS = 2
) (
   input  logic signed [ACC_W-1:0] acc,
   output logic signed [OUT_W-1:0] value,
   output logic                    sat
);

   // One guard bit so adding the rounding constant cannot wrap.
   localparam int unsigned SUM_W = ACC_W + 1;
   localparam logic signed [SUM_W-1:0] MAX_V = SUM_W'((1 << (OUT_W - 1)) - 1);
   localparam logic signed [SUM_W-1:0] MIN_V = ~MAX_V;

   logic signed [SUM_W-1:0] half_c;
   logic signed [SUM_W-1:0] sum_c;
   logic signed [SUM_W-1:0] rounded_c;

   generate
      if (FRAC_BITS == 0) begin : g_no_round
         assign half_c = '0;
      end else begin : g_round
         assign half_c = SUM_W'(1) << (FRAC_BITS - 1);
      end
   endgenerate

   always_comb begin
      sum_c     = SUM_W'(acc) + half_c;
      rounded_c = sum_c >>> FRAC_BITS;
      value     = OUT_W'(rounded_c);
      sat       = 1'b0;
      if (rounded_c > MAX_V) begin
         value = OUT_W'(MAX_V);
         sat   = 1'b1;
      end else if (rounded_c < MIN_V) begin
         value = OUT_W'(MIN_V);
         sat   = 1'b1;
      end
   end

endmodule

// File: rtl/fir_tdm_mac.sv
// Multi-channel FIR filter sharing one multiply-accumulate unit across taps and channels,
// with runtime-programmable coefficients and a rounded, saturated, channel-tagged output.
module fir_tdm_mac
   import fir_tdm_pkg::*;
#(
   parameter  int unsigned DATA_W    = 8,
   parameter  int unsigned COEF_W    = 8,
   parameter  int unsigned OUT_W     = 9,
   parameter  int unsigned NUM_TAPS  = 5,
   parameter  int unsigned NUM_CH    = 2,
   parameter  int unsigned FRAC_BITS = 2,
   localparam int unsigned CH_W      = fir_ch_w(NUM_CH),
   localparam int unsigned TAP_W     = fir_tap_w(NUM_TAPS)
) (
   input  logic                     clk,
   input  logic                     rst_b,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [CH_W-1:0]          in_ch,
   input  logic signed [DATA_W-1:0] in_data,
   input  logic                     coef_we,
   input  logic [TAP_W-1:0]         coef_addr,
   input  logic signed [COEF_W-1:0] coef_wdata,
   output logic                     coef_err,
   output logic                     out_valid,
   output logic [CH_W-1:0]          out_ch,
   output logic signed [OUT_W-1:0]  out_data,
   output logic                     out_sat
);

   localparam int unsigned ACC_W  = fir_acc_w(DATA_W, COEF_W, NUM_TAPS);
   localparam int unsigned PROD_W = DATA_W + COEF_W;
   localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NUM_TAPS - 1);

   fir_state_e state;
   logic [TAP_W-1:0]         k;
   logic [CH_W-1:0]          ch;
   logic signed [ACC_W-1:0]  acc;

   logic signed [DATA_W-1:0] taps [NUM_CH][NUM_TAPS];
   logic signed [COEF_W-1:0] coef [NUM_TAPS];

   logic                     accept_c;
   logic                     ch_ok_c;
   logic                     addr_ok_c;
   logic                     load_c;
   logic                     coef_wr_c;
   logic signed [DATA_W-1:0] tap_k_c;
   logic signed [COEF_W-1:0] coef_k_c;
   logic signed [PROD_W-1:0] prod_c;
   logic signed [OUT_W-1:0]  rs_value_c;
   logic                     rs_sat_c;

   // Range checks collapse to constants when the index field exactly fits the count.
   generate
      if (NUM_CH == (1 << CH_W)) begin : g_ch_full
         assign ch_ok_c = 1'b1;
      end else begin : g_ch_part
         assign ch_ok_c = (in_ch < CH_W'(NUM_CH));
      end
      if (NUM_TAPS == (1 << TAP_W)) begin : g_tap_full
         assign addr_ok_c = 1'b1;
      end else begin : g_tap_part
         assign addr_ok_c = (coef_addr < TAP_W'(NUM_TAPS));
      end
   endgenerate

   // A coefficient write in IDLE takes the cycle, so samples wait one clock.
   assign in_ready  = rst_b & (state == IDLE) & ~coef_we;
   assign accept_c  = in_valid & in_ready;
   assign load_c    = accept_c & ch_ok_c;
   assign coef_wr_c = coef_we & (state == IDLE) & addr_ok_c;

   assign tap_k_c  = taps[ch][k];
   assign coef_k_c = coef[k];
   assign prod_c   = PROD_W'(tap_k_c) * PROD_W'(coef_k_c);

   // Per-channel delay lines: only the accepting channel shifts.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         for (int c = 0; c < NUM_CH; c++) begin
            for (int t = 0; t < NUM_TAPS; t++) begin
               taps[c][t] <= '0;
            end
         end
      end else if (load_c) begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (in_ch == CH_W'(c)) begin
               taps[c][0] <= in_data;
               for (int t = 1; t < NUM_TAPS; t++) begin
                  taps[c][t] <= taps[c][t-1];
               end
            end
         end
      end
   end

   // Coefficient register file, shared by all channels.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         for (int t = 0; t < NUM_TAPS; t++) begin
            coef[t] <= '0;
         end
      end else if (coef_wr_c) begin
         for (int t = 0; t < NUM_TAPS; t++) begin
            if (coef_addr == TAP_W'(t)) begin
               coef[t] <= coef_wdata;
            end
         end
      end
   end

   fir_round_sat #(
      .ACC_W     (ACC_W),
      .OUT_W     (OUT_W),
      .FRAC_BITS (FRAC_BITS)
   ) u_round_sat (
      .acc   (acc),
      .value (rs_value_c),
      .sat   (rs_sat_c)
   );

   // Sequencer: one tap per MAC cycle, then a single result cycle.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state     <= IDLE;
         k         <= '0;
         ch        <= '0;
         acc       <= '0;
         coef_err  <= 1'b0;
         out_valid <= 1'b0;
         out_ch    <= '0;
         out_data  <= '0;
         out_sat   <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         coef_err  <= coef_we & (state != IDLE);
         case (state)
            IDLE: begin
               if (load_c) begin
                  ch    <= in_ch;
                  acc   <= '0;
                  k     <= '0;
                  state <= MAC;
               end
            end
            MAC: begin
               acc <= acc + ACC_W'(prod_c);
               k   <= k + TAP_W'(1);
               if (k == LAST_TAP) begin
                  state <= OUT;
               end
            end
            OUT: begin
               out_valid <= 1'b1;
               out_ch    <= ch;
               out_data  <= rs_value_c;
               out_sat   <= rs_sat_c;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fir_tdm_mac.sv
// Directed bench for fir_tdm_mac: impulse, saturation, rounding, channel isolation,
// coefficient write arbitration and mid-computation reset.
module tb_fir_tdm_mac;

   logic              clk = 1'b0;
   logic              rst_b;
   logic              in_valid;
   logic              in_ready;
   logic [0:0]        in_ch;
   logic signed [7:0] in_data;
   logic              coef_we;
   logic [2:0]        coef_addr;
   logic signed [7:0] coef_wdata;
   logic              coef_err;
   logic              out_valid;
   logic [0:0]        out_ch;
   logic [8:0]        out_data;
   logic              out_sat;

   logic              in_valid3;
   logic              in_ready3;
   logic [1:0]        in_ch3;
   logic signed [7:0] in_data3;
   logic              coef_err3;
   logic              out_valid3;
   logic [1:0]        out_ch3;
   logic [8:0]        out_data3;
   logic              out_sat3;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   int ov_cnt   = 0;
   int ov3_cnt  = 0;

   int exp_imp [5] = '{1, 0, 1, -1, 2};
   int imp_cf  [5] = '{2, -2, 4, -4, 8};
   int rnd_in  [4] = '{3, -1, -3, 1};
   int rnd_exp [4] = '{2, 0, -1, 1};

   fir_tdm_mac dut (
      .clk        (clk),
      .rst_b      (rst_b),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_ch      (in_ch),
      .in_data    (in_data),
      .coef_we    (coef_we),
      .coef_addr  (coef_addr),
      .coef_wdata (coef_wdata),
      .coef_err   (coef_err),
      .out_valid  (out_valid),
      .out_ch     (out_ch),
      .out_data   (out_data),
      .out_sat    (out_sat)
   );

   // Three-channel instance so a two-bit channel field can carry an unused index.
   fir_tdm_mac #(.NUM_CH(3)) dut3 (
      .clk        (clk),
      .rst_b      (rst_b),
      .in_valid   (in_valid3),
      .in_ready   (in_ready3),
      .in_ch      (in_ch3),
      .in_data    (in_data3),
      .coef_we    (1'b0),
      .coef_addr  (3'd0),
      .coef_wdata (8'sd0),
      .coef_err   (coef_err3),
      .out_valid  (out_valid3),
      .out_ch     (out_ch3),
      .out_data   (out_data3),
      .out_sat    (out_sat3)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (out_valid)  ov_cnt  <= ov_cnt + 1;
      if (out_valid3) ov3_cnt <= ov3_cnt + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic write_coef(input logic [2:0] a, input logic signed [7:0] w);
      coef_we    = 1'b1;
      coef_addr  = a;
      coef_wdata = w;
      @(posedge clk); #1;
      coef_we    = 1'b0;
   endtask

   // Sends one sample, optionally pokes a coefficient write mid-MAC, waits for the result.
   task automatic run_sample(input logic [0:0] ch, input logic signed [7:0] d, input bit poke,
                             output int od, output int osat, output int och,
                             output int lat, output int acc_cyc);
      int n;
      in_valid = 1'b1;
      in_ch    = ch;
      in_data  = d;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check_eq("accept_timeout", 0, 1);
      @(posedge clk); #1;
      acc_cyc  = cyc;
      in_valid = 1'b0;
      if (poke) begin
         @(posedge clk); #1;
         coef_we    = 1'b1;
         coef_addr  = 3'd0;
         coef_wdata = 8'sd100;
         @(posedge clk); #1;
         coef_we = 1'b0;
         check_eq("coef_err_pulse", int'(coef_err), 1);
         check_eq("mac_in_ready", int'(in_ready), 0);
         @(posedge clk); #1;
         check_eq("coef_err_clear", int'(coef_err), 0);
      end
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) check_eq("out_timeout", 0, 1);
      lat  = cyc - acc_cyc;
      od   = int'($signed(out_data));
      osat = int'(out_sat);
      och  = int'(out_ch);
      @(posedge clk); #1;
      check_eq("out_valid_pulse", int'(out_valid), 0);
   endtask

   initial begin
      int od, osat, och, lat, ac, w, base;
      rst_b      = 1'b0;
      in_valid   = 1'b0;
      in_ch      = '0;
      in_data    = '0;
      coef_we    = 1'b0;
      coef_addr  = '0;
      coef_wdata = '0;
      in_valid3  = 1'b0;
      in_ch3     = '0;
      in_data3   = '0;

      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_in_ready", int'(in_ready), 0);
      check_eq("rst_out_valid", int'(out_valid), 0);
      check_eq("rst_out_data", int'(out_data), 0);
      check_eq("rst_out_sat", int'(out_sat), 0);
      check_eq("rst_coef_err", int'(coef_err), 0);
      rst_b = 1'b1;
      @(posedge clk); #1;
      check_eq("idle_in_ready", int'(in_ready), 1);

      // Impulse response, with a rejected coefficient write during the first MAC
      for (int t = 0; t < 5; t++) write_coef(3'(t), 8'(imp_cf[t]));
      for (int i = 0; i < 5; i++) begin
         run_sample(1'b0, (i == 0) ? 8'sd1 : 8'sd0, (i == 0), od, osat, och, lat, ac);
         check_eq($sformatf("imp%0d_data", i), od, exp_imp[i]);
         check_eq($sformatf("imp%0d_lat", i), lat, 6);
         check_eq($sformatf("imp%0d_sat", i), osat, 0);
         check_eq($sformatf("imp%0d_ch", i), och, 0);
      end

      // Positive saturation on ch1
      for (int t = 0; t < 5; t++) write_coef(3'(t), 8'sd127);
      for (int i = 0; i < 5; i++) begin
         run_sample(1'b1, 8'sd127, 1'b0, od, osat, och, lat, ac);
         check_eq($sformatf("psat%0d_data", i), od, 255);
         check_eq($sformatf("psat%0d_sat", i), osat, 1);
         check_eq($sformatf("psat%0d_ch", i), och, 1);
      end

      // Negative saturation on ch0
      for (int i = 0; i < 5; i++) begin
         run_sample(1'b0, -8'sd128, 1'b0, od, osat, och, lat, ac);
         check_eq($sformatf("nsat%0d_data", i), od, -256);
         check_eq($sformatf("nsat%0d_sat", i), osat, 1);
      end

      // Round-half-up on both signs: coef = {2,0,0,0,0}
      write_coef(3'd0, 8'sd2);
      for (int t = 1; t < 5; t++) write_coef(3'(t), 8'sd0);
      for (int i = 0; i < 4; i++) begin
         run_sample(1'b1, 8'(rnd_in[i]), 1'b0, od, osat, och, lat, ac);
         check_eq($sformatf("rnd%0d_data", i), od, rnd_exp[i]);
         check_eq($sformatf("rnd%0d_sat", i), osat, 0);
      end

      // Out-of-range address ignored; coefficient write and sample in the same cycle
      write_coef(3'd5, 8'sd99);
      w          = cyc;
      coef_we    = 1'b1;
      coef_addr  = 3'd0;
      coef_wdata = 8'sd4;
      in_valid   = 1'b1;
      in_ch      = 1'b0;
      in_data    = 8'sd8;
      #1;
      check_eq("we_blocks_ready", int'(in_ready), 0);
      @(posedge clk); #1;
      coef_we = 1'b0;
      run_sample(1'b0, 8'sd8, 1'b0, od, osat, och, lat, ac);
      check_eq("we_then_accept_cyc", ac, w + 2);
      check_eq("iso_ch0a_data", od, 8);
      run_sample(1'b1, 8'sd0, 1'b0, od, osat, och, lat, ac);
      check_eq("iso_ch1_data", od, 0);
      check_eq("iso_ch1_ch", och, 1);
      run_sample(1'b0, 8'sd8, 1'b0, od, osat, och, lat, ac);
      check_eq("iso_ch0b_data", od, 8);
      check_eq("iso_ch0b_ch", och, 0);

      // Unused channel index is consumed without a result
      in_valid3 = 1'b1;
      in_ch3    = 2'd3;
      in_data3  = 8'sd50;
      @(negedge clk);
      check_eq("inv_ch_ready", int'(in_ready3), 1);
      @(posedge clk); #1;
      in_valid3 = 1'b0;
      base = ov3_cnt;
      repeat (10) @(posedge clk);
      #1;
      check_eq("inv_ch_no_out", ov3_cnt - base, 0);
      check_eq("inv_ch_idle", int'(in_ready3), 1);
      in_valid3 = 1'b1;
      in_ch3    = 2'd2;
      in_data3  = 8'sd5;
      @(posedge clk); #1;
      in_valid3 = 1'b0;
      base = ov3_cnt;
      repeat (10) @(posedge clk);
      #1;
      check_eq("ch2_one_out", ov3_cnt - base, 1);
      check_eq("ch2_out_ch", int'(out_ch3), 2);
      check_eq("ch2_out_data", int'(out_data3), 0);
      check_eq("ch2_out_sat", int'(out_sat3), 0);
      check_eq("ch2_coef_err", int'(coef_err3), 0);

      // Reset during the third MAC cycle
      in_valid = 1'b1;
      in_ch    = 1'b0;
      in_data  = 8'sd8;
      @(negedge clk);
      check_eq("mid_rst_ready", int'(in_ready), 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_b = 1'b0;
      #1;
      check_eq("mid_rst_in_ready", int'(in_ready), 0);
      check_eq("mid_rst_out_data", int'(out_data), 0);
      check_eq("mid_rst_out_ch", int'(out_ch), 0);
      check_eq("mid_rst_out_sat", int'(out_sat), 0);
      @(posedge clk); #1;
      rst_b = 1'b1;
      base = ov_cnt;
      repeat (12) @(posedge clk);
      #1;
      check_eq("mid_rst_no_out", ov_cnt - base, 0);
      run_sample(1'b0, 8'sd1, 1'b0, od, osat, och, lat, ac);
      check_eq("post_rst_data", od, 0);
      check_eq("post_rst_lat", lat, 6);
      run_sample(1'b1, 8'sd127, 1'b0, od, osat, och, lat, ac);
      check_eq("post_rst_data2", od, 0);
      check_eq("post_rst_sat2", osat, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
